// File: rtl/warp_scheduler.sv
// Round-robin multi-warp fetch/issue scheduler between instruction memory and SP cores.
// Optional perf counters enabled by defining WARP_SCHED_PERF_EN.
module warp_scheduler #(
    parameter int NUM_WARPS   = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int INST_LENGTH = 32,
    localparam int WW = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_pc,
    input  logic                   all_mask_true,
    output logic                   inst_req,
    output logic [ADDR_WIDTH-1:0]  inst_addr,
    input  logic                   inst_valid,
    input  logic [INST_LENGTH-1:0] inst,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [WW-1:0]          warp_id,
    output logic [3:0]             opcode,
    output logic [3:0]             x,
    output logic [3:0]             y,
    output logic [3:0]             z,
    output logic [15:0]            I,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_stall
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        FETCH,
        ISSUE
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [ADDR_WIDTH-1:0]    pc [NUM_WARPS];
    logic [NUM_WARPS-1:0]     active;
    logic [WW-1:0]            rr_ptr;
    logic [WW-1:0]            cur_warp;
    logic [INST_LENGTH-1:0]   inst_q;

    logic                     sel_found;
    logic [WW-1:0]            sel_warp;
    logic [WW-1:0]            next_warp;
    logic [ADDR_WIDTH-1:0]    cur_pc;
    logic [ADDR_WIDTH-1:0]    imm_pc;
    logic                     is_jmp;
    logic                     is_bra;
    logic                     is_exit;
    logic                     is_ctrl;

    assign cur_pc    = pc[cur_warp];
    assign imm_pc    = inst[ADDR_WIDTH-1:0];
    assign is_jmp    = (inst[31:28] == 4'h8);
    assign is_bra    = (inst[31:28] == 4'h9);
    assign is_exit   = (inst[31:28] == 4'hF);
    assign is_ctrl   = is_jmp | is_bra | is_exit;
    assign next_warp = (cur_warp == WW'(NUM_WARPS - 1)) ? '0 : cur_warp + WW'(1);

    // Scan from the highest offset down so the nearest active warp wins.
    always_comb begin
        int j;
        sel_found = 1'b0;
        sel_warp  = '0;
        j         = 0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_WARPS) j = j - NUM_WARPS;
            if (active[j]) begin
                sel_found = 1'b1;
                sel_warp  = WW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        unique case (state)
            IDLE:   if (start) state_n = SELECT;
            SELECT: begin
                if (sel_found) begin
                    state_n = FETCH;
                end else begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            FETCH:  if (inst_valid) state_n = is_ctrl ? SELECT : ISSUE;
            ISSUE:  if (issue_ready) state_n = SELECT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) pc[w] <= '0;
            active   <= '0;
            rr_ptr   <= '0;
            cur_warp <= '0;
            inst_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int w = 0; w < NUM_WARPS; w++) pc[w] <= start_pc;
                        active <= '1;
                        rr_ptr <= '0;
                    end
                end
                SELECT: if (sel_found) cur_warp <= sel_warp;
                FETCH: begin
                    if (inst_valid) begin
                        unique case (1'b1)
                            is_jmp:  pc[cur_warp] <= imm_pc;
                            is_bra:  pc[cur_warp] <= all_mask_true ? imm_pc
                                                   : cur_pc + ADDR_WIDTH'(1);
                            is_exit: active[cur_warp] <= 1'b0;
                            default: inst_q <= inst;
                        endcase
                        if (is_ctrl) rr_ptr <= next_warp;
                    end
                end
                ISSUE: begin
                    if (issue_ready) begin
                        pc[cur_warp] <= cur_pc + ADDR_WIDTH'(1);
                        rr_ptr       <= next_warp;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign inst_req    = (state == FETCH);
    assign inst_addr   = inst_req ? cur_pc : '0;
    assign issue_valid = (state == ISSUE);
    assign warp_id     = cur_warp;
    assign opcode      = inst_q[31:28];
    assign x           = inst_q[27:24];
    assign y           = inst_q[23:20];
    assign z           = inst_q[19:16];
    assign I           = inst_q[15:0];

`ifdef WARP_SCHED_PERF_EN
    logic [31:0] issued_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (issue_valid && issue_ready) issued_cnt <= issued_cnt + 32'd1;
            if ((state == FETCH && !inst_valid) || (state == ISSUE && !issue_ready))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_issued = issued_cnt;
    assign perf_stall  = stall_cnt;
`else
    assign perf_issued = 32'd0;
    assign perf_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed self-checking bench for warp_scheduler (4 warps, 8-bit PC).
module tb_warp_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_pc;
    logic        all_mask_true;
    logic        inst_req;
    logic [7:0]  inst_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  warp_id;
    logic [3:0]  opcode, x, y, z;
    logic [15:0] I;
    logic        busy, done;
    logic [31:0] perf_issued, perf_stall;

    logic        auto_mode;
    logic        man_valid, man_ready;
    logic [31:0] man_inst;
    logic [31:0] script [64];
    logic        clr;

    int fidx, icnt, dcnt, cyc;
    logic [7:0] faddr [64];
    logic [1:0] iw    [64];
    logic [3:0] iop   [64];
    int         icyc  [64];

    int total = 0;
    int bad   = 0;

    warp_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .all_mask_true(all_mask_true), .inst_req(inst_req),
        .inst_addr(inst_addr), .inst_valid(inst_valid), .inst(inst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .warp_id(warp_id), .opcode(opcode), .x(x), .y(y), .z(z), .I(I),
        .busy(busy), .done(done), .perf_issued(perf_issued),
        .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    assign inst_valid  = auto_mode ? inst_req : man_valid;
    assign issue_ready = auto_mode ? 1'b1 : man_ready;
    assign inst        = auto_mode ? script[fidx[5:0]] : man_inst;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            fidx <= 0;
            icnt <= 0;
            dcnt <= 0;
        end else begin
            if (inst_req && inst_valid) begin
                faddr[fidx[5:0]] <= inst_addr;
                fidx <= fidx + 1;
            end
            if (issue_valid && issue_ready) begin
                iw[icnt[5:0]]   <= warp_id;
                iop[icnt[5:0]]  <= opcode;
                icyc[icnt[5:0]] <= cyc;
                icnt <= icnt + 1;
            end
            if (done) dcnt <= dcnt + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clr   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic fill_script(input logic [31:0] v);
        for (int i = 0; i < 64; i++) script[i] = v;
    endtask

    task automatic launch(input logic [7:0] p);
        @(negedge clk);
        start    = 1'b1;
        start_pc = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL rst_inst_req got %b want 0", inst_req); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_issue_valid got %b want 0", issue_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
        total++; if (inst_addr !== 8'h00) begin bad++; $display("FAIL rst_inst_addr got %h want 00", inst_addr); end
        total++; if ({warp_id, opcode, x, y, z, I} !== '0) begin bad++; $display("FAIL rst_fields got %h want 0", {warp_id, opcode, x, y, z, I}); end
        total++; if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin bad++; $display("FAIL rst_perf got %0d/%0d want 0/0", perf_issued, perf_stall); end
    endtask

    task automatic test_round_robin();
        int ew [5] = '{0, 1, 2, 3, 0};
        logic [7:0] ea [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        do_reset();
        auto_mode = 1'b1;
        fill_script(32'h0123_0000);
        launch(8'h00);
        total++; if (inst_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rr_select req=%b busy=%b want 0/1", inst_req, busy); end
        @(negedge clk);
        total++; if (inst_req !== 1'b1 || inst_addr !== 8'h00) begin bad++; $display("FAIL rr_first_req req=%b addr=%h want 1/00", inst_req, inst_addr); end
        repeat (19) @(negedge clk);
        total++; if (icnt < 5) begin bad++; $display("FAIL rr_count got %0d want >=5", icnt); end
        for (int k = 0; k < 5; k++) begin
            total++; if (iw[k] !== 2'(ew[k])) begin bad++; $display("FAIL rr_warp[%0d] got %0d want %0d", k, iw[k], ew[k]); end
            total++; if (faddr[k] !== ea[k]) begin bad++; $display("FAIL rr_addr[%0d] got %h want %h", k, faddr[k], ea[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (icyc[k+1] - icyc[k] !== 3) begin bad++; $display("FAIL rr_gap[%0d] got %0d want 3", k, icyc[k+1] - icyc[k]); end
        end
    endtask

    task automatic test_exit();
        int ew [6] = '{0, 2, 3, 0, 2, 3};
        int n;
        do_reset();
        auto_mode = 1'b1;
        fill_script(32'hF000_0000);
        for (int i = 0; i < 7; i++) script[i] = 32'h0000_0000;
        script[1] = 32'hF000_0000;
        launch(8'h00);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL exit_timeout busy=%b want 0", busy); end
        repeat (3) @(negedge clk);
        total++; if (dcnt !== 1) begin bad++; $display("FAIL exit_done_pulses got %0d want 1", dcnt); end
        total++; if (icnt !== 6) begin bad++; $display("FAIL exit_issues got %0d want 6", icnt); end
        for (int k = 0; k < 6; k++) begin
            total++; if (iw[k] !== 2'(ew[k])) begin bad++; $display("FAIL exit_warp[%0d] got %0d want %0d", k, iw[k], ew[k]); end
        end
    endtask

    task automatic test_branch(input logic m, input logic [7:0] ea);
        do_reset();
        auto_mode     = 1'b1;
        all_mask_true = m;
        fill_script(32'h0000_0000);
        script[0] = 32'h9000_0040;
        launch(8'h00);
        repeat (16) @(negedge clk);
        total++; if (faddr[4] !== ea) begin bad++; $display("FAIL bra_target m=%b got %h want %h", m, faddr[4], ea); end
        total++; if (iw[0] !== 2'd1 || iop[0] !== 4'h0) begin bad++; $display("FAIL bra_not_issued m=%b warp=%0d op=%h want 1/0", m, iw[0], iop[0]); end
        total++; if (iw[3] !== 2'd0) begin bad++; $display("FAIL bra_w0_issue m=%b got %0d want 0", m, iw[3]); end
        all_mask_true = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] es, ei;
`ifdef WARP_SCHED_PERF_EN
        es = 32'd5; ei = 32'd1;
`else
        es = 32'd0; ei = 32'd0;
`endif
        do_reset();
        auto_mode = 1'b0;
        man_valid = 1'b0;
        man_ready = 1'b0;
        man_inst  = 32'h1234_ABCD;
        launch(8'h00);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++; if (inst_req !== 1'b1 || inst_addr !== 8'h00) begin bad++; $display("FAIL stall_fetch[%0d] req=%b addr=%h want 1/00", k, inst_req, inst_addr); end
            @(negedge clk);
        end
        man_valid = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if ({issue_valid, warp_id, opcode, x, y, z, I} !== {1'b1, 2'd0, 32'h1234_ABCD}) begin
                bad++; $display("FAIL stall_issue[%0d] got %h want %h", k, {issue_valid, warp_id, opcode, x, y, z, I}, {1'b1, 2'd0, 32'h1234_ABCD});
            end
            if (k == 2) man_ready = 1'b1;
            @(negedge clk);
        end
        man_ready = 1'b0;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL stall_after got %b want 0", issue_valid); end
        total++; if (perf_stall !== es) begin bad++; $display("FAIL perf_stall got %0d want %0d", perf_stall, es); end
        total++; if (perf_issued !== ei) begin bad++; $display("FAIL perf_issued got %0d want %0d", perf_issued, ei); end
    endtask

    task automatic test_wrap();
        do_reset();
        auto_mode = 1'b1;
        fill_script(32'h0000_0000);
        launch(8'hFF);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        start_pc = 8'h33;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++; if (faddr[k] !== 8'hFF) begin bad++; $display("FAIL wrap_first[%0d] got %h want ff", k, faddr[k]); end
        end
        total++; if (faddr[4] !== 8'h00) begin bad++; $display("FAIL wrap_next got %h want 00", faddr[4]); end
        total++; if (faddr[5] !== 8'h00) begin bad++; $display("FAIL wrap_w1_next got %h want 00", faddr[5]); end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        auto_mode = 1'b0;
        man_valid = 1'b1;
        man_ready = 1'b0;
        man_inst  = 32'h0000_0000;
        launch(8'h10);
        @(negedge clk);
        @(negedge clk);
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL mid_pre issue_valid=%b want 1", issue_valid); end
        #2 reset = 1'b0;
        #1;
        total++; if ({issue_valid, inst_req, busy} !== 3'b000) begin bad++; $display("FAIL mid_drop got %b want 000", {issue_valid, inst_req, busy}); end
        @(negedge clk);
        reset     = 1'b1;
        man_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || inst_req !== 1'b0) begin bad++; $display("FAIL mid_idle busy=%b req=%b want 0/0", busy, inst_req); end
        launch(8'h10);
        @(negedge clk);
        total++; if (inst_req !== 1'b1 || inst_addr !== 8'h10) begin bad++; $display("FAIL mid_refetch req=%b addr=%h want 1/10", inst_req, inst_addr); end
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        start_pc      = 8'h00;
        all_mask_true = 1'b0;
        auto_mode     = 1'b1;
        man_valid     = 1'b0;
        man_ready     = 1'b0;
        man_inst      = 32'h0;
        clr           = 1'b1;
        cyc           = 0;
        fill_script(32'h0);
        test_reset();
        test_round_robin();
        test_exit();
        test_branch(1'b1, 8'h40);
        test_branch(1'b0, 8'h01);
        test_stall();
        test_wrap();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Parametrised multi-warp successor to the single-thread scheduler in the SM core. It keeps one program counter per warp, selects warps round-robin, fetches each instruction from instruction memory over a request/valid handshake, and issues decoded fields to the SP cores over a valid/ready handshake. Control-flow opcodes (jump, branch, exit) are consumed internally and never issued. It sits between the instruction memory and the SP-core array.

## Interface
- NUM_WARPS, 4: number of warps (≥2); warp index width WW = clog2(NUM_WARPS).
- ADDR_WIDTH, 8: instruction address and PC width.
- INST_LENGTH, 32: instruction width; fields fixed at opcode[31:28], x[27:24], y[23:20], z[19:16], I[15:0].
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch pulse; sampled only in IDLE.
- start_pc  in  ADDR_WIDTH  initial PC for every warp.
- all_mask_true  in  1  from SP array; branch condition for BRA.
- inst_req  out  1  fetch request.
- inst_addr  out  ADDR_WIDTH  fetch address (PC of current warp).
- inst_valid  in  1  instruction memory returns inst.
- inst  in  INST_LENGTH  fetched instruction.
- issue_valid  out  1  issued instruction valid.
- issue_ready  in  1  SP cores accept.
- warp_id  out  WW  warp of issued instruction.
- opcode / x / y / z  out  4 each  decoded fields.
- I  out  16  immediate.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when last warp exits.
- perf_issued, perf_stall  out  32 each  see Configuration.

## Operation
- Per-warp state: pc[w] (ADDR_WIDTH), active[w]; rr_ptr (WW); cur_warp (WW); inst_q (latched instruction).
- FSM states IDLE, SELECT, FETCH, ISSUE.
- IDLE: on start=1 → all active=1, all pc=start_pc, rr_ptr=0, → SELECT. start in any other state ignored.
- SELECT: choose first active warp scanning rr_ptr, rr_ptr+1, … wrapping mod NUM_WARPS; latch cur_warp → FETCH. If no warp active → done=1 for this cycle, → IDLE.
- FETCH: inst_req=1, inst_addr=pc[cur_warp], held stable until inst_valid. On inst_valid, decode inst[31:28]:
  - 4'h8 JMP: pc=I[ADDR_WIDTH-1:0]; → SELECT.
  - 4'h9 BRA: pc=I[ADDR_WIDTH-1:0] if all_mask_true else pc+1; → SELECT.
  - 4'hF EXIT: active[cur_warp]=0; → SELECT.
  - any other: inst_q=inst → ISSUE.
  - in all three control cases rr_ptr=cur_warp+1 mod NUM_WARPS.
- ISSUE: issue_valid=1, fields from inst_q, warp_id=cur_warp; held stable until issue_ready. On issue_ready: pc[cur_warp]=pc+1, rr_ptr=cur_warp+1 mod NUM_WARPS, → SELECT.
- PC arithmetic modulo 2^ADDR_WIDTH (pc=all-ones +1 → 0); I truncated to low ADDR_WIDTH bits.
- inst_valid outside FETCH and issue_ready outside ISSUE ignored.

## Timing
- Reset (any time, incl. mid-fetch/issue): state IDLE, all active=0, pc=0, rr_ptr=0, inst_q=0; inst_req, issue_valid, busy, done=0; inst_addr, warp_id, opcode, x, y, z, I = 0; perf counters 0.
- Outputs registered or decoded from registered state only; no combinational path inst_valid→inst_req or issue_ready→issue_valid.
- Minimum per issued instruction: 3 cycles (SELECT, FETCH with same-cycle inst_valid, ISSUE with same-cycle issue_ready). Control op minimum 2 cycles.
- start to first inst_req: 2 cycles (IDLE→SELECT→FETCH).
- Last EXIT accepted at edge n → SELECT in n+1 with done=1 → IDLE, busy=0 at n+2.

## Configuration
- WARP_SCHED_PERF_EN defined: perf_issued increments on each issue_valid&issue_ready handshake; perf_stall increments each cycle in FETCH with !inst_valid or ISSUE with !issue_ready; both wrap at 2^32, cleared by reset only (not by start).
- Undefined: counters not built; perf_issued and perf_stall tied to 0.

## Test plan
- Reset mid-ISSUE with issue_valid=1: assert reset=0 → issue_valid, inst_req, busy drop immediately; after release, start needed to resume; start_pc=0x10 refetched at 0x10.
- NUM_WARPS=4, start_pc=0x00, memory all NOPs, zero-latency handshakes → warp_id sequence 0,1,2,3,0; each warp's inst_addr 0x00 then 0x01; one issue every 3 cycles.
- Warp 1 fetches EXIT at 0x00, others NOP → subsequent rotation 0,2,3,0; after all four EXIT, done pulses once, busy falls.
- BRA I=0x40 with all_mask_true=1 → warp's next inst_addr 0x40; with all_mask_true=0 → 0x01; neither issued (issue_valid stays 0).
- inst_valid delayed 3 cycles and issue_ready delayed 2 → inst_addr and issued fields stable throughout; with WARP_SCHED_PERF_EN perf_stall=5, perf_issued=1.
- ADDR_WIDTH=8, pc=0xFF NOP issued → next inst_addr for that warp 0x00; start asserted while busy has no effect.
